// File: rtl/div_sequencer_pkg.sv
// Shared CPU definitions used by the divide sequencer and the decoder that feeds it.
package cpu_defs;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    // Sequencer state encoding, kept as plain constants for legacy compatibility
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // SPECIAL-opcode funct codes the decoder maps onto start/signed_div
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    // True when a SPECIAL funct selects either divide flavour
    function automatic logic is_div_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division step: shift in the next dividend bit and try to
// subtract the divisor from the partial remainder.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             qbit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // Trial subtraction; keep the shifted remainder when the divisor does not fit
    always_comb begin
        shifted  = {prem, dbit};
        borrow   = shifted < {2'b00, divisor};
        diff     = shifted[WIDTH:0] - {1'b0, divisor};
        next_rem = borrow ? shifted[WIDTH:0] : diff;
        qbit     = ~borrow;
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider sequencer for the execute stage.
// Stalls the pipeline while iterating and strobes quotient/remainder for the
// HI/LO write for exactly one cycle.
module div_sequencer
    import cpu_defs::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             stall,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;      // dividend bits still to consume, quotient bits shifted in below
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem     (prem),
        .dbit     (dvd[WIDTH-1]),
        .divisor  (dvs),
        .next_rem (step_rem),
        .qbit     (step_q)
    );

    // Accept decision, operand magnitudes and raw results of the current step
    always_comb begin
        accept = (state == IDLE) && start && !annul;
        abs_a  = (signed_div && opa[WIDTH-1]) ? ('0 - opa) : opa;
        abs_b  = (signed_div && opb[WIDTH-1]) ? ('0 - opb) : opb;
        q_fin  = {dvd[WIDTH-2:0], step_q};
        r_fin  = step_rem[WIDTH-1:0];
    end

    // Pipeline freeze; forced low while reset is held so the abort is immediate
    always_comb begin
        stall = rst && (accept || (state == RUN));
    end

    // Sequencer FSM, iteration counter and sign fix-up of the final result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            quot  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd   <= abs_a;
                        dvs   <= abs_b;
                        prem  <= '0;
                        cnt   <= '0;
                        neg_q <= signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        neg_r <= signed_div && opa[WIDTH-1];
                        if (opb == '0) begin
                            state <= DONE;
                            valid <= 1'b1;
                            quot  <= '1;
                            rem   <= opa;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (annul) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        prem <= step_rem;
                        dvd  <= q_fin;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            quot  <= neg_q ? ('0 - q_fin) : q_fin;
                            rem   <= neg_r ? ('0 - r_fin) : r_fin;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          signed_div = 1'b0;
    logic [W-1:0]  opa = '0;
    logic [W-1:0]  opb = '0;
    logic          annul = 1'b0;
    logic          stall;
    logic          busy;
    logic          valid;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall      (stall),
        .busy       (busy),
        .valid      (valid),
        .quot       (quot),
        .rem        (rem)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of DIV/DIVU
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Issue one divide at the current negedge (cycle 0) and follow it to DONE
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic hold);
        logic [31:0] eq;
        logic [31:0] er;
        int          vcyc;
        int          exp_cyc;
        int          stall_bad;
        model(a, b, sgn, eq, er);
        exp_cyc   = (b == 0) ? 1 : W + 1;
        stall_bad = 0;
        vcyc      = -1;
        opa = a;
        opb = b;
        signed_div = sgn;
        annul = 1'b0;
        start = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad++;
        for (int c = 1; c <= W + 5; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                vcyc = c;
                break;
            end
            if (stall !== 1'b1) stall_bad++;
        end
        check($sformatf("%s latency", tag), vcyc, exp_cyc);
        check($sformatf("%s stall_cycles", tag), stall_bad, 0);
        if (vcyc > 0) begin
            check($sformatf("%s stall_done", tag), {31'b0, stall}, 32'd0);
            check($sformatf("%s quot", tag), quot, eq);
            check($sformatf("%s rem", tag), rem, er);
        end
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int          valid_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        // Reset state
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset quot", quot, 32'd0);
        check("reset rem", rem, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed divides
        @(negedge clk); run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk); run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        @(negedge clk); run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        @(negedge clk); run_div("div_by_zero", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        @(negedge clk); run_div("div_by_zero_s", 32'h8765_4321, 32'd0, 1'b1, 1'b0);
        @(negedge clk); run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk); run_div("divu_big", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

        // annul held in IDLE blocks the accept
        @(negedge clk);
        opa = 32'd9; opb = 32'd2; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
        #1;
        check("idle_annul stall", {31'b0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        check("idle_annul busy", {31'b0, busy}, 32'd0);
        start = 1'b0; annul = 1'b0;

        // annul during RUN cancels the divide, then a new one runs cleanly
        @(negedge clk);
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        valid_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid === 1'b1) valid_seen++;
        end
        check("annul busy_c10", {31'b0, busy}, 32'd1);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        if (valid === 1'b1) valid_seen++;
        check("annul stall_c11", {31'b0, stall}, 32'd0);
        check("annul busy_c11", {31'b0, busy}, 32'd0);
        annul = 1'b0;
        @(negedge clk);
        if (valid === 1'b1) valid_seen++;
        check("annul no_valid", valid_seen, 0);
        run_div("annul_next_9_3", 32'd9, 32'd3, 1'b0, 1'b0);

        // Back-to-back: start held through DONE does not restart
        @(negedge clk); run_div("b2b_first", 32'd50, 32'd5, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b idle_busy", {31'b0, busy}, 32'd0);
        check("b2b idle_valid", {31'b0, valid}, 32'd0);
        check("b2b idle_stall", {31'b0, stall}, 32'd1);
        run_div("b2b_second", 32'd17, 32'd4, 1'b0, 1'b0);

        // Randomized divides against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 16);
                3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 7);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 100);
            @(negedge clk);
            run_div($sformatf("rand%0d", i), ra, rb, rs, 1'b0);
        end

        // Reset asserted mid-RUN aborts immediately
        @(negedge clk);
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_mid busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b0; start = 1'b0;
        #1;
        check("rst_mid busy", {31'b0, busy}, 32'd0);
        check("rst_mid stall", {31'b0, stall}, 32'd0);
        check("rst_mid valid", {31'b0, valid}, 32'd0);
        check("rst_mid quot", quot, 32'd0);
        check("rst_mid rem", rem, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1) valid_seen++;
        end
        check("rst_mid no_valid", valid_seen, 0);
        check("rst_mid idle_busy", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
